// File: rtl/ex_result_stage.sv
// EX result stage: funnels single-cycle ALU results and multi-cycle mult/div
// results into one registered output entry toward MEM. The entry uses a
// valid/ready handshake. Taken branches and jumps produce a one-cycle
// redirect. A mult/div that never answers is abandoned after MD_TIMEOUT
// cycles and leaves a sticky error flag.
module ex_result_stage #(
  parameter int XLEN       = 32,
  parameter int MD_TIMEOUT = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_md,
  input  logic            in_branch,
  input  logic            in_jump,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_is_zero,
  input  logic            alu_ready,
  input  logic [XLEN-1:0] in_target,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic            out_ready,
  output logic            stall_ex,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            md_timeout
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   md_cnt;
  logic [4:0]      md_rd;
  logic            md_we;
  logic [XLEN-1:0] hold_result;
  logic            hold_we;

  logic            slot_free;
  logic            to_hit;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic            md_result_we;
  logic            load_ex, load_md, load_hold, go_hold;

  // Next state, stall and load selection.
  always_comb begin
    state_d      = state_q;
    stall_ex     = 1'b0;
    load_ex      = 1'b0;
    load_md      = 1'b0;
    load_hold    = 1'b0;
    go_hold      = 1'b0;
    slot_free    = !out_valid || out_ready;
    to_hit       = (md_cnt == CW'(MD_TIMEOUT - 1));
    // A timeout retires the instruction just like a real answer. This keeps
    // the abandoned op from being re-issued when the state returns to IDLE.
    md_done      = alu_ready || to_hit;
    md_result    = alu_ready ? alu_result : '0;
    md_result_we = alu_ready ? md_we : 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_md) begin
            stall_ex = 1'b1;
            state_d  = MD_WAIT;
          end else if (slot_free) begin
            load_ex = 1'b1;
          end else begin
            stall_ex = 1'b1;
          end
        end
      end
      MD_WAIT: begin
        stall_ex = !md_done;
        if (md_done) begin
          if (slot_free) begin
            load_md = 1'b1;
            state_d = IDLE;
          end else begin
            go_hold = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        stall_ex = 1'b1;
        if (slot_free) begin
          load_hold = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) stall_ex = 1'b0;
  end

  // State, mult/div bookkeeping, output entry and redirect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      md_cnt       <= '0;
      md_rd        <= '0;
      md_we        <= 1'b0;
      hold_result  <= '0;
      hold_we      <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      md_timeout   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && in_valid && in_md) begin
        md_cnt <= '0;
        md_rd  <= in_rd;
        md_we  <= in_regwrite;
      end else if (state_q == MD_WAIT) begin
        md_cnt <= md_cnt + 1'b1;
      end

      if (state_q == MD_WAIT && to_hit && !alu_ready) md_timeout <= 1'b1;

      if (go_hold) begin
        hold_result <= md_result;
        hold_we     <= md_result_we;
      end

      if (load_ex) begin
        out_valid    <= 1'b1;
        out_result   <= alu_result;
        out_rd       <= in_rd;
        out_regwrite <= in_regwrite;
      end else if (load_md) begin
        out_valid    <= 1'b1;
        out_result   <= md_result;
        out_rd       <= md_rd;
        out_regwrite <= md_result_we;
      end else if (load_hold) begin
        out_valid    <= 1'b1;
        out_result   <= hold_result;
        out_rd       <= md_rd;
        out_regwrite <= hold_we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      redirect <= load_ex && (in_branch || in_jump) && alu_is_zero;
      if (load_ex && (in_branch || in_jump) && alu_is_zero) redirect_pc <= in_target;
    end
  end

endmodule

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter MD_TIMEOUT, default 40, max cycles waited for a mult/div result.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  an EX instruction is present.
REQ-006 SHALL have port in_md  input  1  that instruction is a multi-cycle mult/div op.
REQ-007 SHALL have port in_branch  input  1  the instruction is a conditional branch.
REQ-008 SHALL have port in_jump  input  1  the instruction is JAL/JALR.
REQ-009 SHALL have port alu_result  input  XLEN  ALU result.
REQ-010 SHALL have port alu_is_zero  input  1  ALU branch-taken flag.
REQ-011 SHALL have port alu_ready  input  1  one-cycle pulse, mult/div result valid this cycle only.
REQ-012 SHALL have port in_target  input  XLEN  branch/jump target PC.
REQ-013 SHALL have port in_rd  input  5  destination register.
REQ-014 SHALL have port in_regwrite  input  1  the instruction writes rd.
REQ-015 SHALL have port out_ready  input  1  downstream (MEM) accepts the output entry.
REQ-016 SHALL have port stall_ex  output  1  combinational; EX inputs are held stable while it is high.
REQ-017 SHALL have output ports out_valid (1), out_result (XLEN), out_rd (5) and out_regwrite (1), forming the registered output entry.
REQ-018 SHALL have port redirect  output  1  one-cycle taken-branch/jump pulse.
REQ-019 SHALL have port redirect_pc  output  XLEN  redirect target.
REQ-020 SHALL have port md_timeout  output  1  sticky error flag.

Function
REQ-021 SHALL implement FSM states IDLE, MD_WAIT, HOLD, each with a registered value.
REQ-022 SHALL consider the output slot free when out_valid==0 or out_ready==1.
REQ-023 SHALL treat an entry as transferred when out_valid&&out_ready, clearing out_valid unless a new entry is loaded in the same cycle.
REQ-024 SHALL, in IDLE with in_valid&&!in_md, load the output entry the same edge and drive stall_ex=0 when the slot is free, and otherwise drive stall_ex=1 and load nothing.
REQ-025 SHALL, in IDLE with in_valid&&in_md, drive stall_ex=1, latch in_rd and in_regwrite, clear the wait counter and enter MD_WAIT.
REQ-026 SHALL, in MD_WAIT, drive stall_ex=!alu_ready and increment the wait counter each cycle.
REQ-027 SHALL, in MD_WAIT with alu_ready=1, load the output entry and return to IDLE if the slot is free, and otherwise capture alu_result into a hold buffer and enter HOLD.
REQ-028 SHALL, in HOLD, drive stall_ex=1 and, once the slot is free, move the hold buffer into the output entry and return to IDLE.
REQ-029 SHALL, when the wait counter reaches MD_TIMEOUT-1 without alu_ready, set md_timeout, load an output entry with result 0 and regwrite 0 (waiting for a free slot in HOLD), and leave MD_WAIT.
REQ-030 SHALL hold md_timeout at 1 until reset.
REQ-031 SHALL, on any output load from a non-md instruction with (in_branch||in_jump)&&alu_is_zero, assert redirect on the next cycle for exactly one cycle with redirect_pc=in_target captured at the load.
REQ-032 SHALL never assert redirect for md instructions.
REQ-033 SHALL keep output entry fields stable while out_valid&&!out_ready.
REQ-034 SHALL ignore in_md, in_branch and in_jump while in_valid=0.
REQ-035 SHALL ignore alu_ready outside MD_WAIT.
REQ-036 SHALL transfer the old output entry and load the new one in the same cycle when a transfer and a new load coincide (back-to-back throughput of 1 per cycle).

Reset
REQ-037 SHALL, when rst_n=0 at a clock edge, set the state to IDLE and clear the wait counter, hold buffer, out_valid, out_result, out_rd, out_regwrite, redirect, redirect_pc and md_timeout to 0.
REQ-038 SHALL drive stall_ex=0 while rst_n=0.
REQ-039 SHALL apply reset even mid-MD_WAIT or mid-HOLD, discarding the pending result.

Verification
REQ-040 SHALL verify that an add with out_ready=1, alu_result=0x0000_0007 and rd=5 gives out_valid=1, out_result=7, out_rd=5 next cycle and stall_ex never asserts.
REQ-041 SHALL verify that a mul with alu_ready pulsing 34 cycles after issue and result 0x12 gives stall_ex high for 34 cycles, low in the ready cycle, and out_result=0x12 next cycle.
REQ-042 SHALL verify that a mul with alu_ready arriving while out_valid=1 and out_ready=0 enters HOLD; raising out_ready 3 cycles later delivers the held result the following cycle.
REQ-043 SHALL verify that a beq with alu_is_zero=1 and in_target=0x0000_0100 gives redirect=1 and redirect_pc=0x100 for one cycle, while alu_is_zero=0 gives no redirect.
REQ-044 SHALL verify that a div with alu_ready never asserting gives md_timeout=1 after 40 MD_WAIT cycles, an entry with result 0 and regwrite 0, and stall released.
REQ-045 SHALL verify that rst_n=0 for one cycle during cycle 10 of MD_WAIT gives state IDLE with all outputs 0, and a later alu_ready is ignored.
